// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, coordinate width
// and the line/frame total helpers used by the coordinate generator.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel clock-enable divider: one-clock pixel_tick every CLK_DIV system clocks,
// first tick in clock CLK_DIV-1 after reset release.
module vga_pixel_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_pixel_div: CLK_DIV must be at least 1");
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Gated by reset so that CLK_DIV=1 (counter pinned at 0) still reads idle in reset.
  assign pixel_tick = reset && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_coord_gen.sv
// Parametrised VGA timing / pixel-coordinate generator with blanked, pin-aligned colour.
// Optional monitor-alignment border enabled by defining VGA_COORD_GEN_BORDER_EN.
module vga_coord_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = 4,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned COLOR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] colors_in,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               h_sync,
  output logic               v_sync,
  output logic [COLOR_W-1:0] colors_out
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_coord_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic               x_wrap;
  logic               y_wrap;
  logic               hs_raw;
  logic               vs_raw;
  logic [COLOR_W-1:0] color_next;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_div (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick)
  );

  assign x_wrap   = (pixel_x == X_LAST);
  assign y_wrap   = (pixel_y == Y_LAST);
  assign video_on = (pixel_x < X_ACT) && (pixel_y < Y_ACT);
  assign hs_raw   = (pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST);
  assign vs_raw   = (pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST);

  // Strobes are registered so they coincide with the wrapped counter value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pixel_tick && x_wrap;
      frame_start <= pixel_tick && x_wrap && y_wrap;
      if (pixel_tick) begin
        if (x_wrap) begin
          pixel_x <= '0;
          pixel_y <= y_wrap ? '0 : pixel_y + 1'b1;
        end else begin
          pixel_x <= pixel_x + 1'b1;
        end
      end
    end
  end

  // NOTE: default assigned first so every path writes color_next and no latch is inferred.
  always_comb begin
    color_next = video_on ? colors_in : '0;
`ifdef VGA_COORD_GEN_BORDER_EN
    if (video_on && (pixel_x == '0 || pixel_x == X_ACT - 1'b1 ||
                     pixel_y == '0 || pixel_y == Y_ACT - 1'b1)) begin
      color_next = '1;
    end
`endif
  end

  // Colour and both syncs share one tick register so they stay mutually aligned at the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colors_out <= '0;
      h_sync     <= ~SYNC_POL;
      v_sync     <= ~SYNC_POL;
    end else if (pixel_tick) begin
      colors_out <= color_next;
      h_sync     <= hs_raw ? SYNC_POL : ~SYNC_POL;
      v_sync     <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_coord_gen.sv
// Directed bench for vga_coord_gen on a 16x8 frame with CLK_DIV=2; expected values hand-computed.
module tb_vga_coord_gen;

  localparam int unsigned H_ACTIVE = 8;
  localparam int unsigned H_FP     = 2;
  localparam int unsigned H_SYNC   = 3;
  localparam int unsigned H_BP     = 3;
  localparam int unsigned V_ACTIVE = 4;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 1;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned COLOR_W  = 3;

`ifdef VGA_COORD_GEN_BORDER_EN
  localparam int BORDER_ON = 1;
`else
  localparam int BORDER_ON = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [COLOR_W-1:0] colors_in = '0;
  logic               pixel_tick;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic               h_sync;
  logic               v_sync;
  logic [COLOR_W-1:0] colors_out;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-scan statistics
  int tick_cnt, hs_ticks, vs_ticks, col_nz, col5, vid_clks;
  int first_hs_x, first_vs_cyc, first_ls, last_ls, ls_cnt, ls_bad;
  int first_fs, last_fs, fs_cnt, x_at2, border_row0;

  vga_coord_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV), .SYNC_POL (1'b0), .COLOR_W (COLOR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .colors_in   (colors_in),
    .pixel_tick  (pixel_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .colors_out  (colors_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic wait_pixel(input int x, input int y, input string tag);
    int n;
    n = 0;
    while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check({tag, "_timeout"}, 32'(pixel_x), 32'(x));
  endtask

  task automatic clear_stats();
    tick_cnt = 0; hs_ticks = 0; vs_ticks = 0; col_nz = 0; col5 = 0; vid_clks = 0;
    first_hs_x = -1; first_vs_cyc = -1; first_ls = -1; last_ls = -1; ls_cnt = 0; ls_bad = 0;
    first_fs = -1; last_fs = -1; fs_cnt = 0; x_at2 = -1;
  endtask

  // Samples cycles 0..n-1 after a release that happened just before the call.
  task automatic scan(input int n);
    for (int cyc = 0; cyc < n; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 2) x_at2 = int'(pixel_x);
      if (cyc < 256) begin
        if (pixel_tick) begin
          tick_cnt++;
          if (!v_sync) vs_ticks++;
          if (colors_out != 3'b000) col_nz++;
          if (colors_out == 3'b101) col5++;
          if (cyc < 32 && !h_sync) hs_ticks++;
        end
        if (video_on) vid_clks++;
      end
      if (!h_sync && first_hs_x < 0) first_hs_x = int'(pixel_x);
      if (!v_sync && first_vs_cyc < 0) first_vs_cyc = cyc;
      if (line_start) begin
        if (first_ls < 0) first_ls = cyc;
        if (last_ls >= 0 && cyc - last_ls != 32) ls_bad++;
        last_ls = cyc;
        ls_cnt++;
      end
      if (frame_start) begin
        if (first_fs < 0) first_fs = cyc;
        last_fs = cyc;
        fs_cnt++;
      end
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tick",    32'(pixel_tick),  32'd0);
    check("rst_x",       32'(pixel_x),     32'd0);
    check("rst_y",       32'(pixel_y),     32'd0);
    check("rst_video",   32'(video_on),    32'd1);
    check("rst_line",    32'(line_start),  32'd0);
    check("rst_frame",   32'(frame_start), 32'd0);
    check("rst_hsync",   32'(h_sync),      32'd1);
    check("rst_vsync",   32'(v_sync),      32'd1);
    check("rst_colors",  32'(colors_out),  32'd0);

    // Release and scan two full frames with colour 101 held
    colors_in = 3'b101;
    reset = 1'b1;
    #1;
    check("tick_clk0", 32'(pixel_tick), 32'd0);
    @(negedge clk);
    check("tick_clk1", 32'(pixel_tick), 32'd1);
    check("x_clk1",    32'(pixel_x),    32'd0);
    clear_stats();
    scan(519);
    check("x_clk2",          32'(x_at2),        32'd1);
    check("ticks_frame",     32'(tick_cnt),     32'd128);
    check("hs_low_ticks",    32'(hs_ticks),     32'd3);
    check("hs_first_x",      32'(first_hs_x),   32'd11);
    check("line_first",      32'(first_ls),     32'd31);
    check("line_spacing",    32'(ls_bad),       32'd0);
    check("line_count",      32'(ls_cnt),       32'd16);
    check("vs_low_ticks",    32'(vs_ticks),     32'd32);
    check("vs_first_cyc",    32'(first_vs_cyc), 32'd161);
    check("frame_first",     32'(first_fs),     32'd255);
    check("frame_spacing",   32'(last_fs - first_fs), 32'd256);
    check("frame_count",     32'(fs_cnt),       32'd2);
    check("video_clks",      32'(vid_clks),     32'd64);
    check("colors_nonzero",  32'(col_nz),       32'd32);
    check("colors_101",      32'(col5),         BORDER_ON ? 32'd12 : 32'd32);

    // Asynchronous reset in the middle of a frame
    wait_pixel(6, 2, "mid_frame");
    check("pre_rst_colors", 32'(colors_out), 32'd5);
    reset = 1'b0;
    #1;
    check("mid_rst_x",      32'(pixel_x),    32'd0);
    check("mid_rst_y",      32'(pixel_y),    32'd0);
    check("mid_rst_colors", 32'(colors_out), 32'd0);
    check("mid_rst_hsync",  32'(h_sync),     32'd1);
    check("mid_rst_vsync",  32'(v_sync),     32'd1);
    check("mid_rst_tick",   32'(pixel_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    clear_stats();
    scan(40);
    check("restart_x_clk2",  32'(x_at2),    32'd1);
    check("restart_no_fs",   32'(fs_cnt),   32'd0);
    check("restart_line",    32'(first_ls), 32'd32);

    // Border override (colors_in zero); pins show the previous pixel
    colors_in = 3'b000;
    wait_pixel(8, 1, "px_8_1");
    check("border_right_7_1", 32'(colors_out), BORDER_ON ? 32'd7 : 32'd0);
    wait_pixel(9, 1, "px_9_1");
    check("blank_8_1",        32'(colors_out), 32'd0);
    wait_pixel(4, 2, "px_4_2");
    check("inner_3_2",        32'(colors_out), 32'd0);
    wait_pixel(1, 0, "px_1_0");
    border_row0 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (pixel_tick && colors_out == 3'b111) border_row0++;
    end
    check("border_row0",      32'(border_row0), BORDER_ON ? 32'd8 : 32'd0);
    wait_pixel(1, 1, "px_1_1");
    check("border_left_0_1",  32'(colors_out), BORDER_ON ? 32'd7 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_coord_gen.md
# vga_coord_gen

Parametrised VGA timing and pixel-coordinate generator. It is the successor to the fixed 640x480 sync logic inside the VGA control path. It divides the system clock down to a pixel tick and produces h_sync, v_sync, pixel coordinates, a video-active flag and frame/line pulses. It also blanks and pin-aligns the colour stream coming from the clock/date/timer character renderers. It sits between the system clock domain and the VGA connector; the renderers consume `pixel_x`/`pixel_y` and return `colors_in`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `CLK_DIV`, 4: system clocks per pixel; must be ≥1 (1 = tick every clock)
- `SYNC_POL`, 0: active level of h_sync/v_sync (0 = active-low)
- `COLOR_W`, 3: colour bus width
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `colors_in` in COLOR_W: renderer colour for the current `pixel_x`/`pixel_y`
- `pixel_tick` out 1: one-clock strobe, once per pixel period
- `pixel_x` out 10: horizontal count, 0..H_TOTAL-1
- `pixel_y` out 10: vertical count, 0..V_TOTAL-1
- `video_on` out 1: high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- `line_start` out 1: one-clock strobe when pixel_x wraps to 0
- `frame_start` out 1: one-clock strobe when pixel_x and pixel_y both wrap to 0
- `h_sync` out 1: pin-aligned horizontal sync
- `v_sync` out 1: pin-aligned vertical sync
- `colors_out` out COLOR_W: pin-aligned, blanked colour

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Both must be ≤1024; an elaboration check enforces this.
- Pixel tick divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pixel_tick` is high in the clock where `div_cnt`==CLK_DIV-1.
- Counters, updated only on `pixel_tick`:
  - `pixel_x` increments; at H_TOTAL-1 it wraps to 0 and `pixel_y` increments.
  - `pixel_y` wraps to 0 after V_TOTAL-1.
- Decode, from the counter values:
  - hs_raw is active for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw is active for pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Output stage, one register per pixel tick:
  - `colors_out` <= video_on ? colors_in : 0
  - `h_sync` <= hs_raw, converted to SYNC_POL polarity
  - `v_sync` <= vs_raw, converted to SYNC_POL polarity
- Strobes:
  - `line_start` and `frame_start` are high in the clock following the tick that performed the wrap.
  - They are concurrent with the new counter value.
- Reset (asserted):
  - `div_cnt`, `pixel_x`, `pixel_y` = 0
  - `pixel_tick`, `line_start`, `frame_start` = 0
  - `colors_out` = 0
  - `h_sync`, `v_sync` = ~SYNC_POL (inactive)
  - `video_on` follows the counters combinationally, so it is 1 at (0,0).
- Reset mid-frame: all of the above apply immediately (asynchronous). The frame restarts at (0,0) on the first clock after deassertion; `frame_start` is not emitted for this restart.

## Timing
- `pixel_tick` period is exactly CLK_DIV clocks. The first tick after reset release is in clock CLK_DIV-1 (counting from 0).
- Counter latency: `pixel_x` changes the clock after `pixel_tick`.
- Pin latency: `colors_out`, `h_sync` and `v_sync` are registered on the same tick.
  - They reflect the previous pixel position: exactly one pixel period of latency, identical for all three, so they stay mutually aligned.
- The renderer must present `colors_in` for the current `pixel_x`/`pixel_y` combinationally, or within CLK_DIV-1 clocks.
- h_sync width is H_SYNC pixels; v_sync width is V_SYNC × H_TOTAL pixels.

## Configuration
- `VGA_COORD_GEN_BORDER_EN`:
  - Defined: any visible pixel with pixel_x ∈ {0, H_ACTIVE-1} or pixel_y ∈ {0, V_ACTIVE-1} drives all-ones on `colors_out`, overriding `colors_in`. Used for monitor alignment.
  - Undefined: no override; `colors_out` is the blanked `colors_in` only.

## Structure
- Shared package `vga_pkg` holds:
  - the default 640x480@60 timing constants (H_*/V_*)
  - the H_TOTAL/V_TOTAL helper functions
  - the coordinate width constant COORD_W = 10
- Sub-module `vga_pixel_div` contains the CLK_DIV counter and `pixel_tick` generation. Everything else stays in `vga_coord_gen`.

## Test plan
Small parameters for all scenarios unless noted: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CLK_DIV=2.
1. Reset with reset=0, then release → every output matches the reset values above; first `pixel_tick` in clock 1 after release; `pixel_x` becomes 1 in clock 2.
2. Horizontal timing → h_sync low for exactly 3 ticks, beginning with the tick after `pixel_x`=10 (one-pixel pin latency); `line_start` every 32 clocks.
3. Vertical timing → v_sync low for 32 ticks starting one pixel after (0,5); `frame_start` every 256 clocks.
4. Blanking with colors_in=3'b101 held → `colors_out`=3'b101 for exactly 8 ticks per visible line (4 lines), 0 otherwise.
5. Reset asserted at (6,2) → outputs reset asynchronously; after release, counting restarts at (0,0) with no `frame_start` pulse.
6. Border, with `VGA_COORD_GEN_BORDER_EN` defined and colors_in=0 → `colors_out`=3'b111 at pixel (0,1) and at all of row 0; `colors_out`=0 at (3,2).
